register_bus_master: RTL and testbench

// - Upstream master for the memory-mapped register bank. Parses command packets from the UART RX byte stream and drives the bank's address, write-data and write-enable inputs.
// - Returns read data as bytes to the UART TX. This is the only bus master on the register interface.
// - Packet format: CMD byte; 0x00 = read, 0x01 = write.
//   - Read packet: CMD, ADDR.
//   - Write packet: CMD, ADDR, D0..D3 (little-endian, D0 = bits 7:0).
//   - Read reply: 4 bytes, LSB first.

---
 rtl/register_bus_master.sv | 133 +++++++++++++
 tb/tb_register_bus_master.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_bus_master.sv
// UART-packet bus master for the register bank: parses read/write packets and returns read data as 4 bytes, LSB first.
// Optional feature macro: WR_ACK_EN (send one 0x06 byte after each completed write).
`timescale 1ns/1ps

module register_bus_master #(
  parameter int TIMEOUT    = 50_000_000,
  parameter int RD_LATENCY = 1
) (
  input  logic        ipClk,
  input  logic        ipnReset,
  input  logic [7:0]  ipRxData,
  input  logic        ipRxValid,
  output logic [7:0]  opTxData,
  output logic        opTxValid,
  input  logic        ipTxReady,
  output logic [7:0]  opAddress,
  output logic [31:0] opWrData,
  output logic        opWrEnable,
  input  logic [31:0] ipRdData,
  output logic        opBusy
);

  localparam int              TW          = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TIMEOUT_MAX = TW'(TIMEOUT);
  localparam logic [1:0]      RD_LAST     = 2'(RD_LATENCY - 1);
  localparam logic [7:0]      ACK_BYTE    = 8'h06;

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, WRITE, RD_WAIT, TX
`ifdef WR_ACK_EN
    , ACK
`endif
  } state_t;

  state_t          state, stateNext;
  logic            isWrite;
  logic [1:0]      byteCnt;
  logic [1:0]      rdCnt;
  logic [TW-1:0]   timeoutCnt;
  logic [31:0]     txShift;
  logic            timedOut;

  // The idle-gap counter only aborts in a cycle with no strobe; a strobe always wins.
  assign timedOut = !ipRxValid && (timeoutCnt == TIMEOUT_MAX);
  assign opBusy   = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ipClk or negedge ipnReset) begin
    if (!ipnReset) state <= IDLE;
    else           state <= stateNext;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    stateNext  = state;
    opTxValid  = 1'b0;
    opTxData   = 8'h00;
    opWrEnable = 1'b0;
    case (state)
      IDLE:    if (ipRxValid && (ipRxData[7:1] == 7'd0)) stateNext = ADDR;
      ADDR: begin
        if (ipRxValid)     stateNext = isWrite ? DATA : RD_WAIT;
        else if (timedOut) stateNext = IDLE;
      end
      DATA: begin
        if (ipRxValid && (byteCnt == 2'd3)) stateNext = WRITE;
        else if (timedOut)                  stateNext = IDLE;
      end
      WRITE: begin
        opWrEnable = 1'b1;
`ifdef WR_ACK_EN
        stateNext  = ACK;
`else
        stateNext  = IDLE;
`endif
      end
      RD_WAIT: if (rdCnt == RD_LAST) stateNext = TX;
      TX: begin
        opTxValid = 1'b1;
        opTxData  = txShift[{byteCnt, 3'b000} +: 8];
        if (ipTxReady && (byteCnt == 2'd3)) stateNext = IDLE;
      end
`ifdef WR_ACK_EN
      ACK: begin
        opTxValid = 1'b1;
        opTxData  = ACK_BYTE;
        if (ipTxReady) stateNext = IDLE;
      end
`endif
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: all datapath registers are plain flops (no RAM), so all of them take the reset.
  always_ff @(posedge ipClk or negedge ipnReset) begin
    if (!ipnReset) begin
      isWrite    <= 1'b0;
      byteCnt    <= 2'd0;
      rdCnt      <= 2'd0;
      timeoutCnt <= '0;
      txShift    <= 32'd0;
      opAddress  <= 8'd0;
      opWrData   <= 32'd0;
    end else begin
      if (((state == ADDR) || (state == DATA)) && !ipRxValid) timeoutCnt <= timeoutCnt + 1'b1;
      else                                                    timeoutCnt <= '0;

      case (state)
        IDLE: if (stateNext == ADDR) isWrite <= ipRxData[0];
        ADDR: if (ipRxValid) begin
          opAddress <= ipRxData;
          byteCnt   <= 2'd0;
          rdCnt     <= 2'd0;
        end
        DATA: if (ipRxValid) begin
          opWrData[{byteCnt, 3'b000} +: 8] <= ipRxData;
          byteCnt                          <= byteCnt + 2'd1;
        end
        RD_WAIT: begin
          if (rdCnt == RD_LAST) begin
            txShift <= ipRdData;
            byteCnt <= 2'd0;
          end else begin
            rdCnt <= rdCnt + 2'd1;
          end
        end
        TX: if (ipTxReady) byteCnt <= byteCnt + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_register_bus_master.sv
// Self-checking bench for register_bus_master: directed scenarios plus randomized packets against a
// packet-level model (register array + expected write/reply queues). Honours WR_ACK_EN like the RTL.
`timescale 1ns/1ps

module tb_register_bus_master;

  localparam int TIMEOUT = 100;
  localparam int RD_LAT  = 1;

  logic        ipClk = 1'b0;
  logic        ipnReset;
  logic [7:0]  ipRxData;
  logic        ipRxValid;
  logic [7:0]  opTxData;
  logic        opTxValid;
  logic        ipTxReady;
  logic [7:0]  opAddress;
  logic [31:0] opWrData;
  logic        opWrEnable;
  logic [31:0] ipRdData;
  logic        opBusy;

  register_bus_master #(.TIMEOUT(TIMEOUT), .RD_LATENCY(RD_LAT)) dut (
    .ipClk(ipClk), .ipnReset(ipnReset), .ipRxData(ipRxData), .ipRxValid(ipRxValid),
    .opTxData(opTxData), .opTxValid(opTxValid), .ipTxReady(ipTxReady),
    .opAddress(opAddress), .opWrData(opWrData), .opWrEnable(opWrEnable),
    .ipRdData(ipRdData), .opBusy(opBusy)
  );

  always #5 ipClk = ~ipClk;

  int checks = 0;
  int errors = 0;
  bit bpRandom = 1'b0;

  // Register bank seen by the DUT: starts at a fixed pattern, updated only by observed write strobes.
  function automatic logic [31:0] initVal(input logic [7:0] a);
    return (a == 8'h02) ? 32'h1234_5678 : {a ^ 8'h5A, ~a, a + 8'h33, a};
  endfunction

  bit [31:0] bank [256];
  bit        bankValid [256];
  assign ipRdData = bankValid[opAddress] ? bank[opAddress] : initVal(opAddress);

  // Packet-level expectation: what the bank should hold, which writes and which TX bytes should appear.
  logic [31:0] model [256];
  logic [7:0]  txQ[$];
  logic [7:0]  expTx[$];
  logic [39:0] wrQ[$];
  logic [39:0] expWr[$];
  int          stallViol = 0;
  logic        prevStall = 1'b0;
  logic [7:0]  prevData  = 8'h00;

  always @(negedge ipClk) begin
    if (ipnReset) begin
      if (opTxValid && ipTxReady) txQ.push_back(opTxData);
      if (opWrEnable) begin
        wrQ.push_back({opAddress, opWrData});
        bank[opAddress]      <= opWrData;
        bankValid[opAddress] <= 1'b1;
      end
      if (prevStall && (!opTxValid || (opTxData !== prevData))) stallViol <= stallViol + 1;
      prevStall <= opTxValid && !ipTxReady;
      prevData  <= opTxData;
    end else begin
      prevStall <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge ipClk);
    #1;
    if (bpRandom) ipTxReady = 1'($urandom_range(0, 1));
  endtask

  task automatic sendByte(input logic [7:0] b);
    ipRxData  = b;
    ipRxValid = 1'b1;
    tick();
    ipRxValid = 1'b0;
  endtask

  task automatic gap(input int maxIdle);
    repeat ($urandom_range(0, maxIdle)) tick();
  endtask

  task automatic sendRead(input logic [7:0] a, input int maxIdle);
    sendByte(8'h00); gap(maxIdle);
    sendByte(a);
    for (int i = 0; i < 4; i++) expTx.push_back(model[a][8*i +: 8]);
  endtask

  task automatic sendWrite(input logic [7:0] a, input logic [31:0] d, input int maxIdle);
    sendByte(8'h01); gap(maxIdle);
    sendByte(a);
    for (int i = 0; i < 4; i++) begin
      gap(maxIdle);
      sendByte(d[8*i +: 8]);
    end
    model[a] = d;
    expWr.push_back({a, d});
`ifdef WR_ACK_EN
    expTx.push_back(8'h06);
`endif
  endtask

  task automatic waitIdle(input int maxCyc, input string tag);
    int n = 0;
    while (opBusy && (n < maxCyc)) begin
      tick();
      n++;
    end
    checks++;
    if (opBusy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle-timeout: opBusy=%0b after %0d cycles, required 0", tag, opBusy, n);
    end
  endtask

  task automatic clearQueues();
    txQ.delete(); expTx.delete(); wrQ.delete(); expWr.delete();
  endtask

  task automatic test_reset();
    ipnReset = 1'b0; ipRxData = 8'h00; ipRxValid = 1'b0; ipTxReady = 1'b1;
    repeat (3) tick();
    checks++; if (opTxValid !== 1'b0)  begin errors++; $display("FAIL reset opTxValid: got %0b want 0", opTxValid); end
    checks++; if (opTxData !== 8'h00)  begin errors++; $display("FAIL reset opTxData: got %0h want 0", opTxData); end
    checks++; if (opAddress !== 8'h00) begin errors++; $display("FAIL reset opAddress: got %0h want 0", opAddress); end
    checks++; if (opWrData !== 32'h0)  begin errors++; $display("FAIL reset opWrData: got %0h want 0", opWrData); end
    checks++; if (opWrEnable !== 1'b0) begin errors++; $display("FAIL reset opWrEnable: got %0b want 0", opWrEnable); end
    checks++; if (opBusy !== 1'b0)     begin errors++; $display("FAIL reset opBusy: got %0b want 0", opBusy); end
    ipnReset = 1'b1;
    tick();
    checks++; if (opBusy !== 1'b0)     begin errors++; $display("FAIL reset-release opBusy: got %0b want 0", opBusy); end
  endtask

  task automatic test_read();
    clearQueues();
    ipTxReady = 1'b1;
    sendByte(8'h00);
    sendByte(8'h02);
    checks++; if (opAddress !== 8'h02) begin errors++; $display("FAIL read opAddress: got %0h want 02", opAddress); end
    checks++; if (opTxValid !== 1'b0)  begin errors++; $display("FAIL read early-valid: got %0b want 0", opTxValid); end
    tick();
    checks++; if (opTxValid !== 1'b1)  begin errors++; $display("FAIL read latency: opTxValid=%0b want 1 at RD_LATENCY+1", opTxValid); end
    expTx = '{8'h78, 8'h56, 8'h34, 8'h12};
    waitIdle(50, "read");
    checks++;
    if (txQ.size() != 4) begin errors++; $display("FAIL read reply-count: got %0d want 4", txQ.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (txQ[i] !== expTx[i]) begin errors++; $display("FAIL read byte%0d: got %0h want %0h", i, txQ[i], expTx[i]); end
    end
  endtask

  task automatic test_write();
    clearQueues();
    ipTxReady = 1'b1;
    sendByte(8'h01); sendByte(8'h02);
    sendByte(8'hAA); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
    model[8'h02] = 32'h0000_00AA;
    checks++; if (opWrEnable !== 1'b1)     begin errors++; $display("FAIL write strobe: got %0b want 1", opWrEnable); end
    checks++; if (opAddress !== 8'h02)     begin errors++; $display("FAIL write addr: got %0h want 02", opAddress); end
    checks++; if (opWrData !== 32'h0000_00AA) begin errors++; $display("FAIL write data: got %0h want aa", opWrData); end
    tick();
    checks++; if (opWrEnable !== 1'b0)     begin errors++; $display("FAIL write one-cycle: got %0b want 0", opWrEnable); end
    waitIdle(50, "write");
    checks++; if (wrQ.size() != 1)         begin errors++; $display("FAIL write count: got %0d want 1", wrQ.size()); end
`ifdef WR_ACK_EN
    checks++;
    if ((txQ.size() != 1) || (txQ[0] !== 8'h06)) begin
      errors++; $display("FAIL write ack: got %0d bytes (first %0h) want one 06", txQ.size(), (txQ.size() > 0) ? txQ[0] : 8'h00);
    end
`else
    checks++; if (txQ.size() != 0) begin errors++; $display("FAIL write silent: got %0d tx bytes want 0", txQ.size()); end
`endif
  endtask

  task automatic test_backpressure();
    int n = 0;
    logic [7:0] a;
    clearQueues();
    a = 8'($urandom_range(0, 255));
    ipTxReady = 1'b1;
    sendRead(a, 0);
    while ((txQ.size() < 1) && (n < 20)) begin tick(); n++; end
    checks++; if (txQ.size() < 1) begin errors++; $display("FAIL bp first-byte: got %0d bytes want >=1", txQ.size()); end
    ipTxReady = 1'b0;
    repeat (10) begin
      tick();
      checks++;
      if ((opTxValid !== 1'b1) || (txQ.size() >= 4) || (opTxData !== expTx[txQ.size()])) begin
        errors++; $display("FAIL bp hold: valid=%0b data=%0h want valid=1 data=%0h", opTxValid, opTxData,
                           (txQ.size() < 4) ? expTx[txQ.size()] : 8'h00);
      end
    end
    ipTxReady = 1'b1;
    waitIdle(50, "bp");
    checks++; if (stallViol != 0) begin errors++; $display("FAIL bp stability: got %0d violations want 0", stallViol); end
    checks++;
    if (txQ.size() != 4) begin errors++; $display("FAIL bp count: got %0d want 4", txQ.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (txQ[i] !== expTx[i]) begin errors++; $display("FAIL bp byte%0d: got %0h want %0h", i, txQ[i], expTx[i]); end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] a;
    clearQueues();
    ipTxReady = 1'b1;
    sendByte(8'h01); sendByte(8'h02); sendByte(8'hAA);
    repeat (TIMEOUT - 10) tick();
    checks++; if (opBusy !== 1'b1) begin errors++; $display("FAIL timeout early-abort: opBusy=%0b want 1", opBusy); end
    repeat (30) tick();
    checks++; if (opBusy !== 1'b0) begin errors++; $display("FAIL timeout abort: opBusy=%0b want 0", opBusy); end
    checks++; if (wrQ.size() != 0) begin errors++; $display("FAIL timeout write: got %0d writes want 0", wrQ.size()); end
    a = 8'($urandom_range(0, 255));
    sendRead(a, 0);
    waitIdle(50, "timeout-read");
    checks++;
    if (txQ.size() != 4) begin errors++; $display("FAIL timeout read-count: got %0d want 4", txQ.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (txQ[i] !== expTx[i]) begin errors++; $display("FAIL timeout byte%0d: got %0h want %0h", i, txQ[i], expTx[i]); end
    end
  endtask

  task automatic test_garbage();
    logic [7:0] a;
    logic [7:0] junk [3];
    clearQueues();
    junk = '{8'h7F, 8'h02, 8'hFF};
    ipTxReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sendByte(junk[i]);
      checks++; if (opBusy !== 1'b0) begin errors++; $display("FAIL garbage %0h: opBusy=%0b want 0", junk[i], opBusy); end
    end
    a = 8'($urandom_range(0, 255));
    ipTxReady = 1'b0;
    sendRead(a, 0);
    sendByte(8'h00); sendByte(8'h01); sendByte(8'h00);
    ipTxReady = 1'b1;
    waitIdle(50, "garbage");
    repeat (3) tick();
    checks++; if (opBusy !== 1'b0) begin errors++; $display("FAIL garbage queued: opBusy=%0b want 0", opBusy); end
    checks++;
    if (txQ.size() != 4) begin errors++; $display("FAIL garbage reply-count: got %0d want 4", txQ.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (txQ[i] !== expTx[i]) begin errors++; $display("FAIL garbage byte%0d: got %0h want %0h", i, txQ[i], expTx[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  a;
    logic [31:0] d;
    clearQueues();
    ipTxReady = 1'b1;
    a = 8'($urandom_range(0, 255));
    d = $urandom;
    sendWrite(a, d, 0);
    sendByte(8'h00);
    sendByte(8'h05);
    waitIdle(50, "b2b");
    repeat (3) tick();
    checks++; if (opBusy !== 1'b0) begin errors++; $display("FAIL b2b dropped-cmd: opBusy=%0b want 0", opBusy); end
    checks++;
    if ((wrQ.size() != 1) || (wrQ[0] !== expWr[0])) begin
      errors++; $display("FAIL b2b write: got %0d writes (first %0h) want one %0h", wrQ.size(), (wrQ.size() > 0) ? wrQ[0] : 40'h0, expWr[0]);
    end
    checks++; if (txQ.size() != expTx.size()) begin errors++; $display("FAIL b2b tx-count: got %0d want %0d", txQ.size(), expTx.size()); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clearQueues();
    ipTxReady = 1'b1;
    sendByte(8'h01); sendByte(8'h03); sendByte(8'h11); sendByte(8'h22);
    ipnReset = 1'b0;
    #1;
    checks++;
    if ({opTxValid, opTxData, opAddress, opWrData, opWrEnable, opBusy} !== '0) begin
      errors++; $display("FAIL rst-data outputs: busy=%0b addr=%0h wdata=%0h we=%0b want all 0", opBusy, opAddress, opWrData, opWrEnable);
    end
    repeat (2) tick();
    ipnReset = 1'b1;
    repeat (10) tick();
    checks++; if (wrQ.size() != 0) begin errors++; $display("FAIL rst-data write: got %0d writes want 0", wrQ.size()); end
    checks++; if (opBusy !== 1'b0) begin errors++; $display("FAIL rst-data busy: got %0b want 0", opBusy); end
    ipTxReady = 1'b0;
    sendByte(8'h00); sendByte(8'h04);
    while (!opTxValid && (n < 20)) begin tick(); n++; end
    checks++; if (opTxValid !== 1'b1) begin errors++; $display("FAIL rst-tx reach: opTxValid=%0b want 1", opTxValid); end
    ipnReset = 1'b0;
    #1;
    checks++;
    if ({opTxValid, opTxData, opBusy, opWrEnable} !== '0) begin
      errors++; $display("FAIL rst-tx outputs: valid=%0b data=%0h busy=%0b want all 0", opTxValid, opTxData, opBusy);
    end
    tick();
    ipnReset  = 1'b1;
    ipTxReady = 1'b1;
    repeat (10) tick();
    checks++; if (txQ.size() != 0) begin errors++; $display("FAIL rst-tx abandoned: got %0d bytes want 0", txQ.size()); end
    checks++; if (wrQ.size() != 0) begin errors++; $display("FAIL rst-tx write: got %0d writes want 0", wrQ.size()); end
  endtask

  task automatic test_random();
    logic [7:0] a;
    clearQueues();
    bpRandom = 1'b1;
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 3) == 0) sendByte(8'($urandom_range(2, 255)));
      a = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) sendWrite(a, $urandom, 3);
      else                           sendRead(a, 3);
      waitIdle(400, "random");
      tick();
    end
    bpRandom  = 1'b0;
    ipTxReady = 1'b1;
    checks++; if (stallViol != 0) begin errors++; $display("FAIL random stability: got %0d violations want 0", stallViol); end
    checks++;
    if (wrQ.size() != expWr.size()) begin errors++; $display("FAIL random write-count: got %0d want %0d", wrQ.size(), expWr.size()); end
    else for (int i = 0; i < expWr.size(); i++) begin
      checks++;
      if (wrQ[i] !== expWr[i]) begin errors++; $display("FAIL random write%0d: got %0h want %0h", i, wrQ[i], expWr[i]); end
    end
    checks++;
    if (txQ.size() != expTx.size()) begin errors++; $display("FAIL random tx-count: got %0d want %0d", txQ.size(), expTx.size()); end
    else for (int i = 0; i < expTx.size(); i++) begin
      checks++;
      if (txQ[i] !== expTx[i]) begin errors++; $display("FAIL random tx%0d: got %0h want %0h", i, txQ[i], expTx[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = initVal(8'(i));
    test_reset();
    test_read();
    test_write();
    test_backpressure();
    test_timeout();
    test_garbage();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
